// File: rtl/ws2812_apb_arbiter.sv
// Two-master APB arbiter in front of the shared WS2812 slave, with round-robin tie-break.
// Optional ACCESS timeout: define WS2812_ARB_TIMEOUT_EN.
module ws2812_apb_arbiter #(
  parameter int ADDR_WIDTH     = 6,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_psel_i,
  input  logic                  m0_penable_i,
  input  logic                  m0_pwrite_i,
  input  logic [ADDR_WIDTH-1:0] m0_paddr_i,
  input  logic [31:0]           m0_pwdata_i,
  output logic [31:0]           m0_prdata_o,
  output logic                  m0_pready_o,
  output logic                  m0_pslverr_o,
  input  logic                  m1_psel_i,
  input  logic                  m1_penable_i,
  input  logic                  m1_pwrite_i,
  input  logic [ADDR_WIDTH-1:0] m1_paddr_i,
  input  logic [31:0]           m1_pwdata_i,
  output logic [31:0]           m1_prdata_o,
  output logic                  m1_pready_o,
  output logic                  m1_pslverr_o,
  output logic                  s_psel_o,
  output logic                  s_penable_o,
  output logic                  s_pwrite_o,
  output logic [ADDR_WIDTH-1:0] s_paddr_o,
  output logic [31:0]           s_pwdata_o,
  input  logic [31:0]           s_prdata_i,
  input  logic                  s_pready_i,
  input  logic                  s_pslverr_i,
  output logic [1:0]            grant_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [1:0]            r_grant;
  logic                  r_last_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_write;
  logic [31:0]           r_rdata;
  logic                  r_slverr;
  logic                  r_pready;
  logic                  w_pick_m1;
  logic                  w_timeout;
  logic                  w_unused;

  // penable from the masters carries no information the arbiter needs; psel is the request.
  assign w_unused = &{1'b0, m0_penable_i, m1_penable_i};

  // On a tie, m1 wins only if m0 was the last owner.
  assign w_pick_m1 = m1_psel_i & (~m0_psel_i | ~r_last_grant);

`ifdef WS2812_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_tmo_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || r_state != ACCESS) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == ACCESS) && (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (m0_psel_i || m1_psel_i) w_state_next = SETUP;
      SETUP:   w_state_next = ACCESS;
      ACCESS:  if (s_pready_i || w_timeout) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_grant      <= 2'b00;
      r_last_grant <= 1'b1;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_write      <= 1'b0;
      r_rdata      <= '0;
      r_slverr     <= 1'b0;
      r_pready     <= 1'b0;
    end else begin
      r_pready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (m0_psel_i || m1_psel_i) begin
            r_grant      <= w_pick_m1 ? 2'b10 : 2'b01;
            r_last_grant <= w_pick_m1;
            r_addr       <= w_pick_m1 ? m1_paddr_i  : m0_paddr_i;
            r_wdata      <= w_pick_m1 ? m1_pwdata_i : m0_pwdata_i;
            r_write      <= w_pick_m1 ? m1_pwrite_i : m0_pwrite_i;
          end
        end
        ACCESS: begin
          // A slave response in the timeout cycle takes priority over the timeout error.
          if (s_pready_i) begin
            r_pready <= 1'b1;
            r_rdata  <= s_prdata_i;
            r_slverr <= s_pslverr_i;
          end else if (w_timeout) begin
            r_pready <= 1'b1;
            r_rdata  <= '0;
            r_slverr <= 1'b1;
          end
        end
        DONE:    r_grant <= 2'b00;
        default: ;
      endcase
    end
  end

  assign s_psel_o     = (r_state == SETUP) || (r_state == ACCESS);
  assign s_penable_o  = (r_state == ACCESS);
  assign s_pwrite_o   = r_write;
  assign s_paddr_o    = r_addr;
  assign s_pwdata_o   = r_wdata;
  assign grant_o      = r_grant;

  assign m0_pready_o  = r_pready & r_grant[0];
  assign m1_pready_o  = r_pready & r_grant[1];
  assign m0_prdata_o  = m0_pready_o ? r_rdata : '0;
  assign m1_prdata_o  = m1_pready_o ? r_rdata : '0;
  assign m0_pslverr_o = m0_pready_o & r_slverr;
  assign m1_pslverr_o = m1_pready_o & r_slverr;

endmodule
